mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
// - Responder for the load/store buffer's byte-serial memory protocol and for instruction-fetch word requests.
// - Arbitrates both onto the single byte-wide RAM port (1-cycle read latency) and returns per-byte acks / assembled words.
// - Sits between the SLB and the instruction fetcher on one side and the external RAM/IO bus on the other.
// PARAMETERS
// - ADDR_WIDTH  32       RAM/IO address width
// - IO_BASE     32'h30000 addresses with [17:16]==2'b11 are IO; writes there obey io_buffer_full
// PORTS
// - clk_in          in   1   clock
// - rst_in          in   1   synchronous reset, active-high
// - rdy_in          in   1   0 = freeze all state, ram_wr forced 0
// - lsb_req         in   1   SLB byte request (held until lsb_ack)
// - lsb_wr          in   1   1 = byte write
// - lsb_addr        in   32  byte address
// - lsb_wdata       in   8   byte to write
// - lsb_ack         out  1   1-cycle pulse: byte done
// - lsb_rdata       out  8   read byte, valid only while lsb_ack=1
// - if_req          in   1   fetch request (held until if_valid or clear_in)
// - if_addr         in   32  word address (byte address of byte 0)
// - if_valid        out  1   1-cycle pulse: if_inst valid
// - if_inst         out  32  little-endian assembled word
// - clear_in        in   1   mispredict flush: abort in-flight fetch
// - io_buffer_full  in   1   IO write backpressure
// - ram_din         in   8   RAM read data (addr from previous cycle)
// - ram_dout        out  8   RAM write data
// - ram_a           out  32  RAM address
// - ram_wr          out  1   1 = write this cycle
// BEHAVIOUR
// - Reset: state IDLE; lsb_ack=0, lsb_rdata=0, if_valid=0, if_inst=0, ram_a=0, ram_dout=0, ram_wr=0, byte counter=0.
// - States: IDLE, LS_WAIT, IF_ISSUE, IF_DRAIN.
// - IDLE arbitration, SLB has priority over fetch; grants occur only in IDLE, never mid-word.
// - SLB byte (cycle N in IDLE): drive ram_a=lsb_addr, ram_wr=lsb_wr, ram_dout=lsb_wdata; go LS_WAIT.
// - LS_WAIT (N+1): ram_wr=0; lsb_ack=1, lsb_rdata=ram_din (reads) or 0 (writes); back to IDLE.
//   Next SLB byte issues no earlier than N+2; req seen in LS_WAIT is ignored. Throughput 2 cycles/byte.
// - IO stall: lsb_req & lsb_wr & lsb_addr[17:16]==2'b11 & io_buffer_full -> stay IDLE, nothing issued, fetch also blocked.
// - Fetch (cycle N in IDLE, no lsb_req, !clear_in): IF_ISSUE drives ram_a=if_addr+k at N+k, k=0..3, ram_wr=0.
//   Byte k captured from ram_din at N+k+1 into if_inst[8k+7:8k]; IF_DRAIN covers N+4.
//   if_valid pulses at N+5 (registered); state IDLE at N+5. Fetch latency 5 cycles; address sum wraps mod 2^32.
// - clear_in in any fetch state: next state IDLE, counter=0, no if_valid; partially captured bytes discarded.
//   clear_in does not affect LS_WAIT (store bytes must complete); clear_in in IDLE blocks fetch grant that cycle.
// - if_req dropped mid-word without clear_in: word still completes and if_valid pulses (fetcher ignores).
// - rdy_in=0: state, counters, outputs hold except ram_wr=0; a read whose data arrives while frozen is re-issued on resume.
// - Reset mid-operation: immediate return to reset values next edge; no ack/valid pulse produced.
// STRUCTURE
// - Shared package: state enum (IDLE/LS_WAIT/IF_ISSUE/IF_DRAIN), IO_BASE, io-address predicate function.
// - One sub-module: if_word_assembler (2-bit byte counter + 32-bit shift/insert register, clear input).
// - Arbiter + RAM-port muxing stay in mem_ctrl.
// TESTING
// - SLB read: RAM[0x100]=0xAB; lsb_req rd 0x100 at N -> ram_a=0x100 at N, lsb_ack & lsb_rdata=0xAB at N+1.
// - SLB 4-byte store 0x11223344 @0x200 -> ram_wr bytes 44,33,22,11 at 0x200..0x203, 4 acks spaced 2 cycles.
// - Fetch: RAM[0x0..3]=13,05,00,00; if_req 0x0 at N -> if_valid at N+5, if_inst=0x00000513.
// - Contention: lsb_req and if_req same cycle -> SLB byte first; fetch starts N+2; lsb_req arriving mid-fetch waits until IDLE.
// - Flush: clear_in at N+2 of fetch -> no if_valid, IDLE at N+3; new if_req 0x40 yields correct word.
// - IO: write 0x30000 with io_buffer_full=1 for 5 cycles -> ram_wr stays 0, no ack; drops -> write issued next cycle, ack after.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// Holds the state encoding, the IO window base and the IO-address check.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LS_WAIT  = 2'd1,
      IF_ISSUE = 2'd2,
      IF_DRAIN = 2'd3
   } state_t;

   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   // An address is IO when its [17:16] field matches the IO window.
   function automatic logic is_io(input logic [1:0] addr_hi, input logic [1:0] base_hi);
      return addr_hi == base_hi;
   endfunction

endpackage

// File: rtl/mem_ctrl_if_word_assembler.sv
// Collects four fetched bytes little-endian into one instruction word.
// The byte counter selects the lane written on each capture; clear drops a partial word.
module if_word_assembler
   import mem_ctrl_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        en,
   input  logic        clear,
   input  logic        capture,
   input  logic [7:0]  din,
   output logic [1:0]  byte_cnt,
   output logic [31:0] word
);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         byte_cnt <= 2'd0;
         word     <= 32'h0;
      end else if (en) begin
         if (clear) begin
            byte_cnt <= 2'd0;
            word     <= 32'h0;
         end else if (capture) begin
            word[{byte_cnt, 3'b000} +: 8] <= din;
            byte_cnt                      <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates SLB byte requests and instruction-fetch words onto one byte-wide RAM port.
// RAM reads have one cycle of latency; the SLB always wins arbitration in IDLE.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no access in flight; grants SLB byte or fetch byte 0 this cycle
//   LS_WAIT  | SLB byte issued last cycle; ack (and read data) this cycle
//   IF_ISSUE | capture fetch byte k-1, issue address of byte k (k = 1..3)
//   IF_DRAIN | capture fetch byte 3; if_valid registered for next cycle
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  lsb_req,
   input  logic                  lsb_wr,
   input  logic [ADDR_WIDTH-1:0] lsb_addr,
   input  logic [7:0]            lsb_wdata,
   output logic                  lsb_ack,
   output logic [7:0]            lsb_rdata,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_valid,
   output logic [31:0]           if_inst,
   input  logic                  clear_in,
   input  logic                  io_buffer_full,
   input  logic [7:0]            ram_din,
   output logic [7:0]            ram_dout,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic                  ram_wr
);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ram_a_q, ram_a_d;
   logic [ADDR_WIDTH-1:0]   if_base_q;
   logic [7:0]              ram_dout_q, ram_dout_d;
   logic                    ram_wr_d;
   logic                    wr_q;
   logic                    if_valid_q, if_valid_d;
   logic                    io_stall;
   logic                    grant_ls, grant_if;
   logic                    capture, asm_clear;
   logic [1:0]              byte_cnt;
   logic [31:0]             word;

   assign io_stall = lsb_req && lsb_wr && io_buffer_full
                     && is_io(lsb_addr[17:16], IO_BASE[17:16]);

   always_comb begin
      state_d    = state_q;
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      ram_wr_d   = 1'b0;
      grant_ls   = 1'b0;
      grant_if   = 1'b0;
      capture    = 1'b0;
      asm_clear  = 1'b0;
      if_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            // A stalled IO write still owns the port, so fetch waits behind it.
            if (lsb_req) begin
               if (!io_stall) begin
                  grant_ls   = 1'b1;
                  ram_a_d    = lsb_addr;
                  ram_dout_d = lsb_wdata;
                  ram_wr_d   = lsb_wr;
                  state_d    = LS_WAIT;
               end
            end else if (if_req && !clear_in) begin
               grant_if = 1'b1;
               ram_a_d  = if_addr;
               state_d  = IF_ISSUE;
            end
         end
         LS_WAIT: begin
            state_d = IDLE;
         end
         IF_ISSUE: begin
            if (clear_in) begin
               asm_clear = 1'b1;
               state_d   = IDLE;
            end else begin
               capture = 1'b1;
               ram_a_d = if_base_q + ADDR_WIDTH'({1'b0, byte_cnt} + 3'd1);
               if (byte_cnt == 2'd2) begin
                  state_d = IF_DRAIN;
               end
            end
         end
         IF_DRAIN: begin
            if (clear_in) begin
               asm_clear = 1'b1;
            end else begin
               capture    = 1'b1;
               if_valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         ram_a_q    <= '0;
         ram_dout_q <= 8'h00;
         if_base_q  <= '0;
         wr_q       <= 1'b0;
         if_valid_q <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         if_valid_q <= if_valid_d;
         if (grant_ls) begin
            wr_q <= lsb_wr;
         end
         if (grant_if) begin
            if_base_q <= if_addr;
         end
      end
   end

   if_word_assembler u_asm (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en       (rdy_in),
      .clear    (asm_clear),
      .capture  (capture),
      .din      (ram_din),
      .byte_cnt (byte_cnt),
      .word     (word)
   );

   // While frozen the port keeps the last issued address, so the pending
   // read's data is still on ram_din when the clock resumes.
   assign ram_a     = rdy_in ? ram_a_d    : ram_a_q;
   assign ram_dout  = rdy_in ? ram_dout_d : ram_dout_q;
   assign ram_wr    = ram_wr_d && rdy_in && !rst_in;
   assign lsb_ack   = (state_q == LS_WAIT) && rdy_in && !rst_in;
   assign lsb_rdata = (lsb_ack && !wr_q) ? ram_din : 8'h00;
   assign if_valid  = if_valid_q;
   assign if_inst   = word;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model plus per-scenario check tasks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        lsb_req, lsb_wr, lsb_ack;
   logic [31:0] lsb_addr;
   logic [7:0]  lsb_wdata, lsb_rdata;
   logic        if_req, if_valid;
   logic [31:0] if_addr, if_inst;
   logic        clear_in, io_buffer_full;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   logic        pl_en;
   logic [17:0] pl_addr;
   logic [7:0]  pl_data;
   logic [7:0]  mem [0:262143];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_in = ~clk_in;

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
      .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
      .clear_in(clear_in), .io_buffer_full(io_buffer_full),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always @(posedge clk_in) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_wr) mem[ram_a[17:0]] <= ram_dout;
      ram_din <= mem[ram_a[17:0]];
   end

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic poke(input logic [17:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      cyc();
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL rst_ack_in_reset: got %0b want 0", lsb_ack); else n_pass++;
      n_chk++; if (ram_wr !== 1'b0) $display("FAIL rst_wr_in_reset: got %0b want 0", ram_wr); else n_pass++;
      cyc(); rst_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h0) $display("FAIL rst_ram_a: got %h want 0", ram_a); else n_pass++;
      n_chk++; if (ram_dout !== 8'h0) $display("FAIL rst_ram_dout: got %h want 0", ram_dout); else n_pass++;
      n_chk++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %0b want 0", if_valid); else n_pass++;
      n_chk++; if (if_inst !== 32'h0) $display("FAIL rst_if_inst: got %h want 0", if_inst); else n_pass++;
      n_chk++; if (lsb_rdata !== 8'h0) $display("FAIL rst_rdata: got %h want 0", lsb_rdata); else n_pass++;
   endtask

   task automatic test_slb_read();
      cyc(); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h100) $display("FAIL rd_addr: got %h want 100", ram_a); else n_pass++;
      n_chk++; if (ram_wr !== 1'b0) $display("FAIL rd_wr: got %0b want 0", ram_wr); else n_pass++;
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL rd_early_ack: got %0b want 0", lsb_ack); else n_pass++;
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b1) $display("FAIL rd_ack: got %0b want 1", lsb_ack); else n_pass++;
      n_chk++; if (lsb_rdata !== 8'hAB) $display("FAIL rd_data: got %h want ab", lsb_rdata); else n_pass++;
      cyc(); lsb_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL rd_ack_pulse: got %0b want 0", lsb_ack); else n_pass++;
   endtask

   task automatic test_store();
      logic [31:0] w;
      w = 32'h1122_3344;
      for (int i = 0; i < 4; i++) begin
         cyc(); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h200 + i; lsb_wdata = w[8*i +: 8];
         @(negedge clk_in);
         n_chk++; if (ram_wr !== 1'b1) $display("FAIL st_wr%0d: got %0b want 1", i, ram_wr); else n_pass++;
         n_chk++; if (ram_a !== 32'h200 + i) $display("FAIL st_addr%0d: got %h want %h", i, ram_a, 32'h200 + i); else n_pass++;
         n_chk++; if (ram_dout !== w[8*i +: 8]) $display("FAIL st_data%0d: got %h want %h", i, ram_dout, w[8*i +: 8]); else n_pass++;
         n_chk++; if (lsb_ack !== 1'b0) $display("FAIL st_noack%0d: got %0b want 0", i, lsb_ack); else n_pass++;
         cyc();
         @(negedge clk_in);
         n_chk++; if (lsb_ack !== 1'b1) $display("FAIL st_ack%0d: got %0b want 1", i, lsb_ack); else n_pass++;
         n_chk++; if (ram_wr !== 1'b0) $display("FAIL st_wr_off%0d: got %0b want 0", i, ram_wr); else n_pass++;
         n_chk++; if (lsb_rdata !== 8'h00) $display("FAIL st_rdata%0d: got %h want 0", i, lsb_rdata); else n_pass++;
      end
      cyc(); lsb_req = 1'b0; lsb_wr = 1'b0;
      cyc(); lsb_req = 1'b1; lsb_addr = 32'h202;
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_rdata !== 8'h22) $display("FAIL st_readback: got %h want 22", lsb_rdata); else n_pass++;
      cyc(); lsb_req = 1'b0;
   endtask

   task automatic test_fetch();
      cyc(); if_req = 1'b1; if_addr = 32'h0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h0) $display("FAIL if_addr0: got %h want 0", ram_a); else n_pass++;
      for (int k = 1; k < 4; k++) begin
         cyc();
         @(negedge clk_in);
         n_chk++; if (ram_a !== k) $display("FAIL if_addr%0d: got %h want %0d", k, ram_a, k); else n_pass++;
         n_chk++; if (if_valid !== 1'b0) $display("FAIL if_early_valid%0d: got %0b want 0", k, if_valid); else n_pass++;
      end
      cyc();
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b0) $display("FAIL if_drain_valid: got %0b want 0", if_valid); else n_pass++;
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1) $display("FAIL if_valid: got %0b want 1", if_valid); else n_pass++;
      n_chk++; if (if_inst !== 32'h0000_0513) $display("FAIL if_inst: got %h want 00000513", if_inst); else n_pass++;
      cyc();
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b0) $display("FAIL if_valid_pulse: got %0b want 0", if_valid); else n_pass++;
   endtask

   task automatic test_contention();
      cyc(); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; if_req = 1'b1; if_addr = 32'h0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h100) $display("FAIL ct_slb_first: got %h want 100", ram_a); else n_pass++;
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_rdata !== 8'hAB || lsb_ack !== 1'b1) $display("FAIL ct_ack: got ack %0b data %h want 1 ab", lsb_ack, lsb_rdata); else n_pass++;
      cyc(); lsb_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h0) $display("FAIL ct_fetch_start: got %h want 0", ram_a); else n_pass++;
      cyc(); lsb_req = 1'b1; lsb_addr = 32'h101;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h1) $display("FAIL ct_no_preempt: got %h want 1", ram_a); else n_pass++;
      cyc();
      cyc();
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0 || ram_wr !== 1'b0) $display("FAIL ct_slb_waits: got ack %0b wr %0b want 0 0", lsb_ack, ram_wr); else n_pass++;
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0513) $display("FAIL ct_word: got v%0b %h want 1 00000513", if_valid, if_inst); else n_pass++;
      n_chk++; if (ram_a !== 32'h101) $display("FAIL ct_slb_grant: got %h want 101", ram_a); else n_pass++;
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_rdata !== 8'hCD || lsb_ack !== 1'b1) $display("FAIL ct_slb_data: got ack %0b data %h want 1 cd", lsb_ack, lsb_rdata); else n_pass++;
      cyc(); lsb_req = 1'b0;
   endtask

   task automatic test_flush();
      cyc(); if_req = 1'b1; if_addr = 32'h0;
      cyc();
      cyc(); clear_in = 1'b1;
      cyc(); clear_in = 1'b0; if_addr = 32'h40;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h40) $display("FAIL fl_idle_regrant: got %h want 40", ram_a); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         cyc();
         @(negedge clk_in);
         n_chk++; if (if_valid !== 1'b0) $display("FAIL fl_no_valid%0d: got %0b want 0", i, if_valid); else n_pass++;
      end
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1 || if_inst !== 32'hDEAD_BEEF) $display("FAIL fl_word: got v%0b %h want 1 deadbeef", if_valid, if_inst); else n_pass++;
   endtask

   task automatic test_clear_idle();
      cyc(); if_req = 1'b1; if_addr = 32'h40; clear_in = 1'b1;
      @(negedge clk_in);
      n_chk++; if (ram_a === 32'h40) $display("FAIL ci_blocked: got %h want not 40", ram_a); else n_pass++;
      cyc(); clear_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h40) $display("FAIL ci_grant: got %h want 40", ram_a); else n_pass++;
      cyc(); cyc(); cyc(); cyc();
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b0) $display("FAIL ci_early_valid: got %0b want 0", if_valid); else n_pass++;
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1 || if_inst !== 32'hDEAD_BEEF) $display("FAIL ci_word: got v%0b %h want 1 deadbeef", if_valid, if_inst); else n_pass++;
   endtask

   task automatic test_io();
      cyc(); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_wdata = 8'h5A; io_buffer_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cyc();
         @(negedge clk_in);
         n_chk++; if (ram_wr !== 1'b0 || lsb_ack !== 1'b0) $display("FAIL io_stall%0d: got wr %0b ack %0b want 0 0", i, ram_wr, lsb_ack); else n_pass++;
      end
      cyc(); io_buffer_full = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_wr !== 1'b1 || ram_a !== 32'h30000 || ram_dout !== 8'h5A) $display("FAIL io_issue: got wr %0b a %h d %h want 1 30000 5a", ram_wr, ram_a, ram_dout); else n_pass++;
      cyc();
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b1) $display("FAIL io_ack: got %0b want 1", lsb_ack); else n_pass++;
      cyc(); lsb_addr = 32'h20004; io_buffer_full = 1'b1;
      @(negedge clk_in);
      n_chk++; if (ram_wr !== 1'b1) $display("FAIL io_non_io_write: got %0b want 1", ram_wr); else n_pass++;
      cyc();
      cyc(); lsb_req = 1'b0; lsb_wr = 1'b0; io_buffer_full = 1'b0;
   endtask

   task automatic test_freeze();
      cyc(); if_req = 1'b1; if_addr = 32'h40;
      cyc();
      cyc(); rdy_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h41) $display("FAIL fz_hold_addr: got %h want 41", ram_a); else n_pass++;
      cyc(); cyc();
      cyc(); rdy_in = 1'b1;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h42) $display("FAIL fz_resume_addr: got %h want 42", ram_a); else n_pass++;
      cyc(); cyc();
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b0) $display("FAIL fz_early_valid: got %0b want 0", if_valid); else n_pass++;
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1 || if_inst !== 32'hDEAD_BEEF) $display("FAIL fz_word: got v%0b %h want 1 deadbeef", if_valid, if_inst); else n_pass++;
      cyc(); lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h210; lsb_wdata = 8'h77; rdy_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_wr !== 1'b0) $display("FAIL fz_wr_forced: got %0b want 0", ram_wr); else n_pass++;
      cyc(); rdy_in = 1'b1;
      @(negedge clk_in);
      n_chk++; if (ram_wr !== 1'b1 || ram_dout !== 8'h77) $display("FAIL fz_wr_resume: got wr %0b d %h want 1 77", ram_wr, ram_dout); else n_pass++;
      cyc();
      cyc(); lsb_wr = 1'b0; lsb_addr = 32'h100;
      cyc(); rdy_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL fz_no_ack: got %0b want 0", lsb_ack); else n_pass++;
      cyc();
      cyc(); rdy_in = 1'b1;
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b1 || lsb_rdata !== 8'hAB) $display("FAIL fz_reissue: got ack %0b data %h want 1 ab", lsb_ack, lsb_rdata); else n_pass++;
      cyc(); lsb_req = 1'b0;
   endtask

   task automatic test_wrap();
      cyc(); if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'hFFFF_FFFE) $display("FAIL wr_addr0: got %h want fffffffe", ram_a); else n_pass++;
      cyc();
      cyc();
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h0) $display("FAIL wr_addr2: got %h want 0", ram_a); else n_pass++;
      cyc(); cyc();
      cyc(); if_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (if_valid !== 1'b1 || if_inst !== 32'h0513_BBAA) $display("FAIL wr_word: got v%0b %h want 1 0513bbaa", if_valid, if_inst); else n_pass++;
   endtask

   task automatic test_reset_mid();
      cyc(); if_req = 1'b1; if_addr = 32'h40;
      cyc();
      cyc(); rst_in = 1'b1; if_req = 1'b0;
      cyc(); rst_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (ram_a !== 32'h0 || if_inst !== 32'h0) $display("FAIL rm_cleared: got a %h inst %h want 0 0", ram_a, if_inst); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         cyc();
         @(negedge clk_in);
         n_chk++; if (if_valid !== 1'b0) $display("FAIL rm_no_valid%0d: got %0b want 0", i, if_valid); else n_pass++;
      end
      cyc(); lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100;
      cyc(); rst_in = 1'b1; lsb_req = 1'b0;
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL rm_no_ack: got %0b want 0", lsb_ack); else n_pass++;
      cyc(); rst_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (lsb_ack !== 1'b0) $display("FAIL rm_no_late_ack: got %0b want 0", lsb_ack); else n_pass++;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1;
      lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'h0; lsb_wdata = 8'h0;
      if_req = 1'b0; if_addr = 32'h0; clear_in = 1'b0; io_buffer_full = 1'b0;
      pl_en = 1'b0; pl_addr = 18'h0; pl_data = 8'h0;
      poke(18'h100, 8'hAB); poke(18'h101, 8'hCD);
      poke(18'h0, 8'h13);   poke(18'h1, 8'h05); poke(18'h2, 8'h00); poke(18'h3, 8'h00);
      poke(18'h40, 8'hEF);  poke(18'h41, 8'hBE); poke(18'h42, 8'hAD); poke(18'h43, 8'hDE);
      poke(18'h3FFFE, 8'hAA); poke(18'h3FFFF, 8'hBB);
      test_reset();
      test_slb_read();
      test_store();
      test_fetch();
      test_contention();
      test_flush();
      test_clear_idle();
      test_io();
      test_freeze();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
